branch_predictor: RTL and testbench

IF-stage branch target buffer with 2-bit saturating direction counters. Each cycle it looks up the fetch PC and supplies a predicted next PC and taken flag. It carries that prediction down to ID alongside the instruction. It learns from the branch resolution computed in ID by the branch-control logic, which consumes this block's `branch_indicator` and compares the carried PC against the resolved target.

---
 rtl/branch_predictor_pkg.sv | 21 ++
 rtl/branch_predictor_if.sv | 25 ++
 rtl/branch_predictor_sat_counter2.sv | 25 ++
 rtl/branch_predictor.sv | 90 +++++++++
 tb/tb_branch_predictor.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/branch_predictor_pkg.sv
// branch_predictor_pkg: BTB geometry, counter encodings and entry layout
// shared by the predictor, its counters and the pipeline interface.
package branch_predictor_pkg;
    localparam int ENTRIES = 16;
    localparam int PC_W = 8;
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 2;
    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } ctr_t;
    localparam ctr_t CTR_INIT = WT;
    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [PC_W-1:0]  target;
        ctr_t             ctr;
    } btb_entry_t;
endpackage

// File: rtl/branch_predictor_if.sv
// branch_predictor_if: fetch lookup, ID prediction and resolution-update
// signals between the pipeline (master) and the predictor (slave).
interface branch_predictor_if;
    import branch_predictor_pkg::*;
    logic [PC_W-1:0] if_pc;
    logic [PC_W-1:0] pred_next_pc;
    logic            pred_taken_if;
    logic            stall;
    logic            flush;
    logic            branch_indicator;
    logic [PC_W-1:0] id_pred_pc;
    logic            upd_valid;
    logic [PC_W-1:0] upd_pc;
    logic            upd_taken;
    logic [PC_W-1:0] upd_target;
    logic [15:0]     mispredict_cnt;
    modport master (
        output if_pc, stall, flush, upd_valid, upd_pc, upd_taken, upd_target,
        input  pred_next_pc, pred_taken_if, branch_indicator, id_pred_pc, mispredict_cnt
    );
    modport slave (
        input  if_pc, stall, flush, upd_valid, upd_pc, upd_taken, upd_target,
        output pred_next_pc, pred_taken_if, branch_indicator, id_pred_pc, mispredict_cnt
    );
endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// branch_predictor_sat_counter2: 2-bit saturating up/down direction counter;
// load (allocation) takes priority over inc/dec.
module branch_predictor_sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_inc,
    input  logic i_dec,
    output ctr_t o_ctr
);
    ctr_t r_ctr;
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_ctr <= SNT;
        else if (i_load)
            r_ctr <= CTR_INIT;
        else if (i_inc && r_ctr != ST)
            r_ctr <= ctr_t'(r_ctr + 2'd1);
        else if (i_dec && r_ctr != SNT)
            r_ctr <= ctr_t'(r_ctr - 2'd1);
    end
    assign o_ctr = r_ctr;
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit direction counters, an ID-stage
// copy of the prediction, and a saturating mispredict counter.
module branch_predictor
    import branch_predictor_pkg::*;
(
    input logic              clk,
    input logic              rst_n,
    branch_predictor_if.slave bp
);
    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag [ENTRIES];
    logic [PC_W-1:0]    r_target [ENTRIES];
    ctr_t               w_ctr [ENTRIES];
    btb_entry_t         w_btb [ENTRIES];
    btb_entry_t         w_look;
    logic [IDX_W-1:0]   w_if_idx;
    logic [IDX_W-1:0]   w_upd_idx;
    logic [TAG_W-1:0]   w_upd_tag;
    logic               w_upd_hit;
    logic               w_mispredict;
    logic               r_branch_indicator;
    logic [PC_W-1:0]    r_id_pred_pc;
    logic [15:0]        r_mispredict_cnt;
    logic               w_unused;

    assign w_unused  = ^{bp.if_pc[1:0], bp.upd_pc[1:0]};
    assign w_if_idx  = bp.if_pc[IDX_W+1:2];
    assign w_upd_idx = bp.upd_pc[IDX_W+1:2];
    assign w_upd_tag = bp.upd_pc[PC_W-1:IDX_W+2];
    assign w_look    = w_btb[w_if_idx];
    assign w_upd_hit = r_valid[w_upd_idx] && r_tag[w_upd_idx] == w_upd_tag;

    // Reads see pre-update contents; gating with rst_n keeps the output clean while reset is held.
    assign bp.pred_taken_if = rst_n && w_look.valid && w_look.tag == bp.if_pc[PC_W-1:IDX_W+2]
                              && w_look.ctr >= WT;
    assign bp.pred_next_pc  = bp.pred_taken_if ? w_look.target : bp.if_pc + PC_W'(4);

    for (genvar g = 0; g < ENTRIES; g++) begin : g_ent
        logic w_sel;
        assign w_sel = bp.upd_valid && w_upd_idx == IDX_W'(g);
        branch_predictor_sat_counter2 u_ctr (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_load (w_sel && !w_upd_hit && bp.upd_taken),
            .i_inc  (w_sel && w_upd_hit && bp.upd_taken),
            .i_dec  (w_sel && w_upd_hit && !bp.upd_taken),
            .o_ctr  (w_ctr[g])
        );
        assign w_btb[g] = '{valid: r_valid[g], tag: r_tag[g], target: r_target[g], ctr: w_ctr[g]};
    end

    // A taken update either refreshes a hit entry or allocates over the slot; both write the same fields.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int k = 0; k < ENTRIES; k++) begin
                r_tag[k]    <= '0;
                r_target[k] <= '0;
            end
        end else if (bp.upd_valid && bp.upd_taken) begin
            r_valid[w_upd_idx]  <= 1'b1;
            r_tag[w_upd_idx]    <= w_upd_tag;
            r_target[w_upd_idx] <= bp.upd_target;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || bp.flush) begin
            r_branch_indicator <= 1'b0;
            r_id_pred_pc       <= '0;
        end else if (!bp.stall) begin
            r_branch_indicator <= bp.pred_taken_if;
            r_id_pred_pc       <= bp.pred_next_pc;
        end
    end

    assign w_mispredict = bp.upd_taken != r_branch_indicator
                          || (bp.upd_taken && r_branch_indicator && bp.upd_target != r_id_pred_pc);

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_mispredict_cnt <= '0;
        else if (bp.upd_valid && w_mispredict && r_mispredict_cnt != 16'hFFFF)
            r_mispredict_cnt <= r_mispredict_cnt + 16'd1;
    end

    assign bp.branch_indicator = r_branch_indicator;
    assign bp.id_pred_pc       = r_id_pred_pc;
    assign bp.mispredict_cnt   = r_mispredict_cnt;
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: vector table for lookup/update/ID behaviour, ID-stage
// results checked through a scoreboard queue, plus reset and saturation sequences.
module tb_branch_predictor;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    branch_predictor_if bp ();
    branch_predictor dut (.clk(clk), .rst_n(rst_n), .bp(bp));

    always #5 clk = ~clk;

    typedef struct {
        bit         uv;
        logic [7:0] upc;
        bit         ut;
        logic [7:0] utg;
        logic [7:0] ifpc;
        bit         st;
        bit         fl;
        bit         etk;
        logic [7:0] enpc;
        bit         ebi;
        logic [7:0] eid;
        logic [15:0] ecnt;
    } vec_t;

    typedef struct {
        int          id;
        bit          bi;
        logic [7:0]  idpc;
        logic [15:0] cnt;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic vec_t mk(bit uv, logic [7:0] upc, bit ut, logic [7:0] utg, logic [7:0] ifpc,
                                bit st, bit fl, bit etk, logic [7:0] enpc, bit ebi, logic [7:0] eid,
                                logic [15:0] ecnt);
        vec_t v;
        v = '{uv, upc, ut, utg, ifpc, st, fl, etk, enpc, ebi, eid, ecnt};
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(logic uv, logic [7:0] upc, logic ut, logic [7:0] utg, logic [7:0] ifpc,
                         logic st, logic fl);
        bp.upd_valid = uv;
        bp.upd_pc = upc;
        bp.upd_taken = ut;
        bp.upd_target = utg;
        bp.if_pc = ifpc;
        bp.stall = st;
        bp.flush = fl;
    endtask

    task automatic apply(int id, vec_t v);
        exp_t e;
        @(negedge clk);
        drive(v.uv, v.upc, v.ut, v.utg, v.ifpc, v.st, v.fl);
        #1;
        chk($sformatf("v%0d pred_taken_if", id), 32'(bp.pred_taken_if), 32'(v.etk));
        chk($sformatf("v%0d pred_next_pc", id), 32'(bp.pred_next_pc), 32'(v.enpc));
        sb.push_back('{id, v.ebi, v.eid, v.ecnt});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk($sformatf("v%0d scoreboard empty", id), 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk($sformatf("v%0d branch_indicator", e.id), 32'(bp.branch_indicator), 32'(e.bi));
            chk($sformatf("v%0d id_pred_pc", e.id), 32'(bp.id_pred_pc), 32'(e.idpc));
            chk($sformatf("v%0d mispredict_cnt", e.id), 32'(bp.mispredict_cnt), 32'(e.cnt));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //         uv upc   ut utg    ifpc  st fl  etk enpc   ebi eid    ecnt
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 8'h10, 0, 0, 0, 8'h14, 0, 8'h14, 16'd0));
        vecs.push_back(mk(1, 8'h10, 1, 8'h40, 8'h20, 0, 0, 0, 8'h24, 0, 8'h24, 16'd1));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 8'h10, 0, 0, 1, 8'h40, 1, 8'h40, 16'd1));
        vecs.push_back(mk(1, 8'h10, 1, 8'h40, 8'h50, 0, 0, 0, 8'h54, 0, 8'h54, 16'd1));
        vecs.push_back(mk(1, 8'h10, 1, 8'h40, 8'h10, 0, 0, 1, 8'h40, 1, 8'h40, 16'd2));
        vecs.push_back(mk(1, 8'h10, 0, 8'h00, 8'h10, 0, 0, 1, 8'h40, 1, 8'h40, 16'd3));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 8'h10, 0, 0, 1, 8'h40, 1, 8'h40, 16'd3));
        vecs.push_back(mk(1, 8'h10, 0, 8'h00, 8'h10, 0, 0, 1, 8'h40, 1, 8'h40, 16'd4));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 8'h10, 0, 0, 0, 8'h14, 0, 8'h14, 16'd4));
        vecs.push_back(mk(1, 8'h10, 0, 8'h00, 8'hFC, 0, 0, 0, 8'h00, 0, 8'h00, 16'd4));
        vecs.push_back(mk(1, 8'h10, 0, 8'h00, 8'h10, 0, 0, 0, 8'h14, 0, 8'h14, 16'd4));
        vecs.push_back(mk(1, 8'h10, 1, 8'h60, 8'h10, 0, 0, 0, 8'h14, 0, 8'h14, 16'd5));
        vecs.push_back(mk(1, 8'h10, 1, 8'h60, 8'h10, 0, 0, 0, 8'h14, 0, 8'h14, 16'd6));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 8'h10, 0, 0, 1, 8'h60, 1, 8'h60, 16'd6));
        vecs.push_back(mk(1, 8'h10, 1, 8'h80, 8'h10, 0, 0, 1, 8'h60, 1, 8'h60, 16'd7));
        vecs.push_back(mk(1, 8'h30, 0, 8'h00, 8'h30, 0, 0, 0, 8'h34, 0, 8'h34, 16'd8));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 8'h30, 0, 0, 0, 8'h34, 0, 8'h34, 16'd8));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 8'h10, 0, 0, 1, 8'h80, 1, 8'h80, 16'd8));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 8'h20, 1, 0, 0, 8'h24, 1, 8'h80, 16'd8));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 8'h20, 1, 0, 0, 8'h24, 1, 8'h80, 16'd8));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 8'h20, 1, 0, 0, 8'h24, 1, 8'h80, 16'd8));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 8'h20, 1, 1, 0, 8'h24, 0, 8'h00, 16'd8));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 8'h10, 0, 1, 1, 8'h80, 0, 8'h00, 16'd8));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 8'h10, 0, 0, 1, 8'h80, 1, 8'h80, 16'd8));

        drive(0, 8'h00, 0, 8'h00, 8'h10, 0, 0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset pred_taken_if", 32'(bp.pred_taken_if), 32'd0);
        chk("reset pred_next_pc", 32'(bp.pred_next_pc), 32'h14);
        chk("reset branch_indicator", 32'(bp.branch_indicator), 32'd0);
        chk("reset id_pred_pc", 32'(bp.id_pred_pc), 32'd0);
        chk("reset mispredict_cnt", 32'(bp.mispredict_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

        // Reset with a live table and a pending allocation: outputs gated, update discarded.
        @(negedge clk);
        rst_n = 1'b0;
        drive(1, 8'h20, 1, 8'h44, 8'h10, 0, 0);
        #1;
        chk("rst held pred_taken_if", 32'(bp.pred_taken_if), 32'd0);
        chk("rst held pred_next_pc", 32'(bp.pred_next_pc), 32'h14);
        @(posedge clk);
        #1;
        chk("rst mid branch_indicator", 32'(bp.branch_indicator), 32'd0);
        chk("rst mid id_pred_pc", 32'(bp.id_pred_pc), 32'd0);
        chk("rst mid mispredict_cnt", 32'(bp.mispredict_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 8'h00, 0, 8'h00, 8'h20, 0, 0);
        #1;
        chk("rst discarded pred_taken_if", 32'(bp.pred_taken_if), 32'd0);
        chk("rst discarded pred_next_pc", 32'(bp.pred_next_pc), 32'h24);
        bp.if_pc = 8'h10;
        #1;
        chk("rst cleared pred_taken_if", 32'(bp.pred_taken_if), 32'd0);
        chk("rst cleared pred_next_pc", 32'(bp.pred_next_pc), 32'h14);

        // Every update mispredicts (ID never predicted taken), so the counter must pin at FFFF.
        @(negedge clk);
        drive(1, 8'h24, 1, 8'h44, 8'h08, 0, 0);
        repeat (65536) @(posedge clk);
        #1;
        chk("mispredict_cnt saturated", 32'(bp.mispredict_cnt), 32'hFFFF);
        @(posedge clk);
        #1;
        chk("mispredict_cnt held", 32'(bp.mispredict_cnt), 32'hFFFF);
        @(negedge clk);
        drive(0, 8'h00, 0, 8'h00, 8'h24, 0, 0);
        #1;
        chk("alloc 24 pred_next_pc", 32'(bp.pred_next_pc), 32'h44);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
